// File: rtl/edu_data_path_p.sv
// Edulent gen-2 datapath: register set, N/C/Z ALU and a req/ack memory port.
// One transfer command per cycle; commands issued during a memory access are dropped.
module edu_data_path_p #(
   parameter int          DATA_W  = 8,
   parameter int          ADDR_W  = 8,
   parameter int unsigned SP_INIT = 2**(ADDR_W-1)-1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [3:0]        i_transfer_cmd,
   input  logic              i_acc_sel,
   input  logic [1:0]        i_cond,
   input  logic [2:0]        i_alu_op,
   input  logic              i_alu_calculate,
   input  logic              i_inc_pc,
   input  logic [1:0]        i_inc_dec_sp,
   input  logic              i_reset_ir,
   input  logic [DATA_W-1:0] i_in,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_busy,
   output logic              o_cmd_err,
   output logic [DATA_W-1:0] o_out,
   output logic [DATA_W-1:0] o_IR,
   output logic [2:0]        o_flags
);

   typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_WR_WAIT} mem_state_e;

   typedef enum logic [3:0] {
      CMD_NOP, CMD_MA_PC, CMD_RD, CMD_IR_MD, CMD_MA_MD, CMD_ACC_MD, CMD_MA_AP, CMD_MA_SP,
      CMD_MD_ACC, CMD_WR, CMD_ACC_R, CMD_BRANCH, CMD_A_IN, CMD_OUT_A, CMD_PC_AP, CMD_MD_PC
   } cmd_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_NOT, ALU_OR, ALU_AND, ALU_XOR, ALU_SHR, ALU_PASS
   } alu_op_e;

   logic [ADDR_W-1:0] pc_q, pc_d, ma_q, ma_d, sp_q, sp_d;
   logic [DATA_W-1:0] ir_q, ir_d, md_q, md_d, a_q, a_d, ap_q, ap_d;
   logic [DATA_W-1:0] r_q, r_d, in_q, in_d, out_q, out_d;
   logic [2:0]        flags_q, flags_d;
   logic              cmd_err_q, cmd_err_d;
   mem_state_e        state_q, state_d;

   cmd_e              cmd;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] acc_val;
   logic [DATA_W:0]   alu_res;
   logic              cond_true;

   assign cmd    = cmd_e'(i_transfer_cmd);
   assign alu_op = alu_op_e'(i_alu_op);

   // Bit DATA_W of alu_res is the carry/borrow for every operation.
   always_comb begin
      acc_val = i_acc_sel ? ap_q : a_q;
      case (alu_op)
         ALU_ADD:  alu_res = {1'b0, acc_val} + {1'b0, md_q};
         ALU_SUB:  alu_res = {1'b0, acc_val} - {1'b0, md_q};
         ALU_NOT:  alu_res = {1'b0, ~a_q};
         ALU_OR:   alu_res = {1'b0, a_q | md_q};
         ALU_AND:  alu_res = {1'b0, a_q & md_q};
         ALU_XOR:  alu_res = {1'b0, a_q ^ md_q};
         ALU_SHR:  alu_res = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
         default:  alu_res = {1'b0, md_q};
      endcase
      case (i_cond)
         2'b00:   cond_true = 1'b1;
         2'b01:   cond_true = flags_q[0];
         2'b10:   cond_true = flags_q[1];
         default: cond_true = flags_q[2];
      endcase
   end

   always_comb begin
      // NOTE: every _d takes its hold value first so no path through this block infers a latch.
      pc_d      = pc_q;
      ma_d      = ma_q;
      sp_d      = sp_q;
      ir_d      = ir_q;
      md_d      = md_q;
      a_d       = a_q;
      ap_d      = ap_q;
      r_d       = r_q;
      out_d     = out_q;
      flags_d   = flags_q;
      state_d   = state_q;
      in_d      = i_in;
      cmd_err_d = 1'b0;

      if (i_inc_pc) pc_d = pc_q + ADDR_W'(1);
      case (i_inc_dec_sp)
         2'b01:   sp_d = sp_q + ADDR_W'(1);
         2'b10:   sp_d = sp_q - ADDR_W'(1);
         default: ;
      endcase
      if (i_alu_calculate) begin
         r_d     = alu_res[DATA_W-1:0];
         flags_d = {alu_res[DATA_W-1], alu_res[DATA_W], alu_res[DATA_W-1:0] == '0};
      end

      if (state_q != ST_IDLE) begin
         cmd_err_d = (cmd != CMD_NOP);
         if (i_mem_ack) begin
            state_d = ST_IDLE;
            if (state_q == ST_RD_WAIT) md_d = i_mem_rdata;
         end
      end else begin
         case (cmd)
            CMD_NOP:    ;
            CMD_MA_PC:  ma_d = pc_q;
            CMD_RD:     state_d = ST_RD_WAIT;
            CMD_IR_MD:  ir_d = md_q;
            CMD_MA_MD:  ma_d = ADDR_W'(md_q);
            CMD_ACC_MD: if (i_acc_sel) ap_d = md_q; else a_d = md_q;
            CMD_MA_AP:  ma_d = ADDR_W'(ap_q);
            CMD_MA_SP:  ma_d = sp_q;
            CMD_MD_ACC: md_d = acc_val;
            CMD_WR:     state_d = ST_WR_WAIT;
            CMD_ACC_R:  if (i_acc_sel) ap_d = r_q; else a_d = r_q;
            CMD_BRANCH: if (cond_true) pc_d = ADDR_W'(md_q);
            CMD_A_IN:   a_d = in_q;
            CMD_OUT_A:  out_d = a_q;
            CMD_PC_AP:  pc_d = ADDR_W'(ap_q);
            CMD_MD_PC:  md_d = DATA_W'(pc_q);
         endcase
      end

      if (i_reset_ir) ir_d = '0;
   end

   // NOTE: reset is sampled on the clock edge and overrides every other update, aborting any access.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q      <= '0;
         ma_q      <= '0;
         sp_q      <= ADDR_W'(SP_INIT);
         ir_q      <= '0;
         md_q      <= '0;
         a_q       <= '0;
         ap_q      <= '0;
         r_q       <= '0;
         in_q      <= '0;
         out_q     <= '0;
         flags_q   <= '0;
         cmd_err_q <= 1'b0;
         state_q   <= ST_IDLE;
      end else begin
         pc_q      <= pc_d;
         ma_q      <= ma_d;
         sp_q      <= sp_d;
         ir_q      <= ir_d;
         md_q      <= md_d;
         a_q       <= a_d;
         ap_q      <= ap_d;
         r_q       <= r_d;
         in_q      <= in_d;
         out_q     <= out_d;
         flags_q   <= flags_d;
         cmd_err_q <= cmd_err_d;
         state_q   <= state_d;
      end
   end

   // o_cmd_err is registered: it is high the cycle after the rejected command.
   assign o_mem_req   = (state_q != ST_IDLE);
   assign o_mem_we    = (state_q == ST_WR_WAIT);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_mem_addr  = ma_q;
   assign o_mem_wdata = md_q;
   assign o_cmd_err   = cmd_err_q;
   assign o_out       = out_q;
   assign o_IR        = ir_q;
   assign o_flags     = flags_q;

endmodule

// File: tb/tb_edu_data_path_p.sv
// Self-checking bench for edu_data_path_p: directed vectors, a 16/10-bit width
// instance, and randomized traffic against an integer-level reference model.
module tb_edu_data_path_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0, acc_sel = 1'b0, alu_calc = 1'b0, inc_pc = 1'b0, reset_ir = 1'b0, mem_ack = 1'b0;
   logic [3:0] cmd = '0;
   logic [1:0] cond = '0, inc_dec_sp = '0;
   logic [2:0] alu_op = '0;
   logic [7:0] in_v = '0, mem_rdata = '0;
   logic       mem_req, mem_we, busy, cmd_err;
   logic [7:0] mem_addr, mem_wdata, out_v, ir_v;
   logic [2:0] flags;

   logic [3:0]  w_cmd = '0;
   logic [2:0]  w_op = '0;
   logic        w_calc = 1'b0;
   logic [15:0] w_in = '0;
   logic        w_req, w_we, w_busy, w_err;
   logic [9:0]  w_addr;
   logic [15:0] w_wdata, w_out, w_ir;
   logic [2:0]  w_flags;

   edu_data_path_p u_dut (
      .i_clk(clk), .i_rst(rst), .i_transfer_cmd(cmd), .i_acc_sel(acc_sel), .i_cond(cond),
      .i_alu_op(alu_op), .i_alu_calculate(alu_calc), .i_inc_pc(inc_pc), .i_inc_dec_sp(inc_dec_sp),
      .i_reset_ir(reset_ir), .i_in(in_v), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_busy(busy), .o_cmd_err(cmd_err), .o_out(out_v), .o_IR(ir_v), .o_flags(flags)
   );

   edu_data_path_p #(.DATA_W(16), .ADDR_W(10)) u_dut16 (
      .i_clk(clk), .i_rst(rst), .i_transfer_cmd(w_cmd), .i_acc_sel(1'b0), .i_cond(2'b00),
      .i_alu_op(w_op), .i_alu_calculate(w_calc), .i_inc_pc(1'b0), .i_inc_dec_sp(2'b00),
      .i_reset_ir(1'b0), .i_in(w_in), .i_mem_ack(1'b0), .i_mem_rdata(16'h0000),
      .o_mem_req(w_req), .o_mem_we(w_we), .o_mem_addr(w_addr), .o_mem_wdata(w_wdata),
      .o_busy(w_busy), .o_cmd_err(w_err), .o_out(w_out), .o_IR(w_ir), .o_flags(w_flags)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, plain integers 0..255.
   int m_pc, m_ir, m_ma, m_md, m_a, m_ap, m_r, m_in, m_out, m_sp, m_n, m_c, m_z, m_err;
   bit m_busy, m_wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int acc, res, cy;
      int nx_pc, nx_ir, nx_ma, nx_md, nx_a, nx_ap, nx_r, nx_out, nx_sp, nx_n, nx_c, nx_z;
      bit nx_busy, nx_wr, taken;
      if (rst) begin
         m_pc = 0; m_ir = 0; m_ma = 0; m_md = 0; m_a = 0; m_ap = 0; m_r = 0; m_in = 0;
         m_out = 0; m_sp = 127; m_n = 0; m_c = 0; m_z = 0; m_err = 0; m_busy = 0; m_wr = 0;
         return;
      end
      nx_pc = m_pc; nx_ir = m_ir; nx_ma = m_ma; nx_md = m_md; nx_a = m_a; nx_ap = m_ap;
      nx_r = m_r; nx_out = m_out; nx_sp = m_sp; nx_n = m_n; nx_c = m_c; nx_z = m_z;
      nx_busy = m_busy; nx_wr = m_wr;
      acc = acc_sel ? m_ap : m_a;
      cy = 0;
      case (int'(alu_op))
         0: begin res = acc + m_md; cy = (res > 255) ? 1 : 0; res = res % 256; end
         1: begin cy = (acc < m_md) ? 1 : 0; res = (acc - m_md + 256) % 256; end
         2: res = 255 - m_a;
         3: res = m_a | m_md;
         4: res = m_a & m_md;
         5: res = m_a ^ m_md;
         6: begin res = m_a / 2; cy = m_a % 2; end
         default: res = m_md;
      endcase
      if (alu_calc) begin
         nx_r = res; nx_c = cy; nx_z = (res == 0) ? 1 : 0; nx_n = (res >= 128) ? 1 : 0;
      end
      if (inc_pc) nx_pc = (m_pc + 1) % 256;
      if (inc_dec_sp == 2'b01) nx_sp = (m_sp + 1) % 256;
      else if (inc_dec_sp == 2'b10) nx_sp = (m_sp + 255) % 256;
      m_err = (m_busy && cmd != 4'h0) ? 1 : 0;
      if (m_busy) begin
         if (mem_ack) begin
            nx_busy = 0;
            if (!m_wr) nx_md = int'(mem_rdata);
         end
      end else begin
         case (int'(cmd))
            1:  nx_ma = m_pc;
            2:  begin nx_busy = 1; nx_wr = 0; end
            3:  nx_ir = m_md;
            4:  nx_ma = m_md;
            5:  if (acc_sel) nx_ap = m_md; else nx_a = m_md;
            6:  nx_ma = m_ap;
            7:  nx_ma = m_sp;
            8:  nx_md = acc;
            9:  begin nx_busy = 1; nx_wr = 1; end
            10: if (acc_sel) nx_ap = m_r; else nx_a = m_r;
            11: begin
               case (int'(cond))
                  0: taken = 1;
                  1: taken = (m_z != 0);
                  2: taken = (m_c != 0);
                  default: taken = (m_n != 0);
               endcase
               if (taken) nx_pc = m_md;
            end
            12: nx_a = m_in;
            13: nx_out = m_a;
            14: nx_pc = m_ap;
            15: nx_md = m_pc;
            default: ;
         endcase
      end
      if (reset_ir) nx_ir = 0;
      m_in = int'(in_v);
      m_pc = nx_pc; m_ir = nx_ir; m_ma = nx_ma; m_md = nx_md; m_a = nx_a; m_ap = nx_ap;
      m_r = nx_r; m_out = nx_out; m_sp = nx_sp; m_n = nx_n; m_c = nx_c; m_z = nx_z;
      m_busy = nx_busy; m_wr = nx_wr;
   endtask

   task automatic compare_all();
      check("model_req", mem_req, m_busy);
      check("model_we", mem_we, m_busy & m_wr);
      check("model_addr", mem_addr, m_ma);
      check("model_wdata", mem_wdata, m_md);
      check("model_busy", busy, m_busy);
      check("model_err", cmd_err, m_err);
      check("model_out", out_v, m_out);
      check("model_ir", ir_v, m_ir);
      check("model_flags", flags, m_n * 4 + m_c * 2 + m_z);
   endtask

   // One clock: step the model, let the edge pass, compare, then return pulse inputs to idle.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      rst = 0; cmd = '0; acc_sel = 0; cond = '0; alu_op = '0; alu_calc = 0; inc_pc = 0;
      inc_dec_sp = '0; reset_ir = 0; mem_ack = 0; mem_rdata = '0;
      w_cmd = '0; w_op = '0; w_calc = 0;
   endtask

   task automatic do_cmd(input logic [3:0] c, input logic sel);
      cmd = c; acc_sel = sel; cycle();
   endtask

   task automatic set_in(input logic [7:0] v);
      in_v = v; cycle();
   endtask

   task automatic load_regs(input logic [7:0] a, input logic [7:0] ap, input logic [7:0] md);
      set_in(ap); do_cmd(4'hC, 0); do_cmd(4'h8, 0); do_cmd(4'h5, 1);
      set_in(md); do_cmd(4'hC, 0); do_cmd(4'h8, 0);
      set_in(a);  do_cmd(4'hC, 0);
   endtask

   task automatic w_do(input logic [3:0] c);
      w_cmd = c; cycle();
   endtask

   typedef struct {
      logic [2:0] op;
      logic       sel;
      logic [7:0] a, ap, md, r;
      logic [2:0] fl;
   } alu_vec_t;

   alu_vec_t vecs[13];

   initial begin
      vecs[0]  = '{3'd0, 1'b0, 8'hFF, 8'h00, 8'h01, 8'h00, 3'b011};
      vecs[1]  = '{3'd1, 1'b0, 8'h05, 8'h00, 8'h07, 8'hFE, 3'b110};
      vecs[2]  = '{3'd0, 1'b1, 8'h00, 8'h70, 8'h20, 8'h90, 3'b100};
      vecs[3]  = '{3'd1, 1'b1, 8'h99, 8'h07, 8'h07, 8'h00, 3'b001};
      vecs[4]  = '{3'd2, 1'b0, 8'h0F, 8'h00, 8'h00, 8'hF0, 3'b100};
      vecs[5]  = '{3'd3, 1'b0, 8'hF0, 8'h00, 8'h0F, 8'hFF, 3'b100};
      vecs[6]  = '{3'd4, 1'b0, 8'hF0, 8'h00, 8'h0F, 8'h00, 3'b001};
      vecs[7]  = '{3'd5, 1'b0, 8'hA5, 8'h00, 8'hFF, 8'h5A, 3'b000};
      vecs[8]  = '{3'd6, 1'b0, 8'h03, 8'h00, 8'h00, 8'h01, 3'b010};
      vecs[9]  = '{3'd6, 1'b0, 8'h80, 8'h00, 8'h00, 8'h40, 3'b000};
      vecs[10] = '{3'd7, 1'b0, 8'h00, 8'h00, 8'h80, 8'h80, 3'b100};
      vecs[11] = '{3'd0, 1'b0, 8'h7F, 8'h00, 8'h01, 8'h80, 3'b100};
      vecs[12] = '{3'd1, 1'b1, 8'h55, 8'h00, 8'h01, 8'hFF, 3'b110};

      // Reset, then SP and fetch.
      rst = 1; cycle();
      check("reset_req", mem_req, 1'b0);
      check("reset_flags", flags, 3'b000);
      check("reset_out", out_v, 8'h00);
      do_cmd(4'h7, 0);
      check("reset_sp", mem_addr, 8'h7F);
      do_cmd(4'h1, 0);
      check("fetch_ma_pc", mem_addr, 8'h00);
      do_cmd(4'h2, 0);
      check("fetch_busy0", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check($sformatf("fetch_busy%0d", i + 1), busy, 1'b1);
         check($sformatf("fetch_addr%0d", i + 1), mem_addr, 8'h00);
      end
      mem_ack = 1; mem_rdata = 8'h11; cycle();
      check("fetch_idle", busy, 1'b0);
      do_cmd(4'h3, 0);
      check("fetch_ir", ir_v, 8'h11);

      // ALU vector table.
      for (int i = 0; i < 13; i++) begin
         load_regs(vecs[i].a, vecs[i].ap, vecs[i].md);
         alu_op = vecs[i].op; acc_sel = vecs[i].sel; alu_calc = 1; cycle();
         check($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
         do_cmd(4'hA, 0);
         do_cmd(4'hD, 0);
         check($sformatf("vec%0d_r", i), out_v, vecs[i].r);
      end

      // Conditional branch: taken beats inc_pc, failed branch lets inc_pc act.
      load_regs(8'h00, 8'h00, 8'h40);
      alu_op = 3'd4; alu_calc = 1; cycle();
      check("br_z_set", flags, 3'b001);
      cmd = 4'hB; cond = 2'b01; inc_pc = 1; cycle();
      do_cmd(4'hF, 0);
      check("br_taken_pc", mem_wdata, 8'h40);
      load_regs(8'h00, 8'h00, 8'h12);
      do_cmd(4'hB, 0);
      alu_op = 3'd7; alu_calc = 1; cycle();
      check("br_z_clr", flags, 3'b000);
      cmd = 4'hB; cond = 2'b01; inc_pc = 1; cycle();
      do_cmd(4'hF, 0);
      check("br_fail_pc", mem_wdata, 8'h13);

      // Commands rejected while a read is pending.
      set_in(8'h77); do_cmd(4'hC, 0); do_cmd(4'hD, 0);
      check("busy_out_pre", out_v, 8'h77);
      set_in(8'h33); do_cmd(4'hC, 0); do_cmd(4'h8, 0); do_cmd(4'h4, 0);
      do_cmd(4'h2, 0);
      do_cmd(4'hD, 0);
      check("busy_out_hold", out_v, 8'h77);
      check("busy_err_d", cmd_err, 1'b1);
      do_cmd(4'h1, 0);
      check("busy_ma_hold", mem_addr, 8'h33);
      check("busy_err_1", cmd_err, 1'b1);
      cycle();
      check("busy_err_drop", cmd_err, 1'b0);
      mem_ack = 1; mem_rdata = 8'hC3; cycle();
      check("busy_md_rdata", mem_wdata, 8'hC3);
      check("busy_done", busy, 1'b0);

      // Stack wrap and zero-wait write.
      for (int i = 0; i < 127; i++) begin
         inc_dec_sp = 2'b10; cycle();
      end
      do_cmd(4'h7, 0);
      check("sp_zero", mem_addr, 8'h00);
      inc_dec_sp = 2'b10; cycle();
      do_cmd(4'h7, 0);
      check("sp_wrap_dn", mem_addr, 8'hFF);
      set_in(8'hAA); do_cmd(4'hC, 0); do_cmd(4'h8, 0);
      do_cmd(4'h9, 0);
      check("wr_req", mem_req, 1'b1);
      check("wr_we", mem_we, 1'b1);
      check("wr_addr", mem_addr, 8'hFF);
      check("wr_wdata", mem_wdata, 8'hAA);
      mem_ack = 1; cycle();
      check("wr_done", mem_req, 1'b0);
      inc_dec_sp = 2'b01; cycle();
      do_cmd(4'h7, 0);
      check("sp_wrap_up", mem_addr, 8'h00);

      // Reset during a write aborts it.
      do_cmd(4'h9, 0);
      check("rstw_req", mem_req, 1'b1);
      rst = 1; cycle();
      check("rstw_req_drop", mem_req, 1'b0);
      check("rstw_busy", busy, 1'b0);
      mem_ack = 1; mem_rdata = 8'hEE; cycle();
      check("rstw_ack_idle", mem_wdata, 8'h00);
      do_cmd(4'hD, 0);
      check("rstw_no_err", cmd_err, 1'b0);

      // 16-bit data / 10-bit address instance.
      w_in = 16'h0001; cycle(); w_do(4'hC); w_do(4'h8);
      w_in = 16'hFFFF; cycle(); w_do(4'hC);
      w_op = 3'd0; w_calc = 1; cycle();
      check("w16_flags", w_flags, 3'b011);
      w_do(4'hA); w_do(4'hD);
      check("w16_r", w_out, 16'h0000);
      w_in = 16'hABCD; cycle(); w_do(4'hC); w_do(4'h8); w_do(4'h4);
      check("w16_ma_trunc", w_addr, 10'h3CD);
      w_do(4'hB); w_do(4'hF);
      check("w16_pc_zext", w_wdata, 16'h03CD);
      check("w16_idle", {w_req, w_we, w_busy, w_err}, 4'b0000);
      check("w16_ir", w_ir, 16'h0000);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 63) == 0);
         cmd        = 4'($urandom_range(0, 15));
         acc_sel    = 1'($urandom_range(0, 1));
         cond       = 2'($urandom_range(0, 3));
         alu_op     = 3'($urandom_range(0, 7));
         alu_calc   = 1'($urandom_range(0, 1));
         inc_pc     = ($urandom_range(0, 3) == 0);
         inc_dec_sp = 2'($urandom_range(0, 3));
         reset_ir   = ($urandom_range(0, 7) == 0);
         in_v       = 8'($urandom_range(0, 255));
         mem_ack    = ($urandom_range(0, 2) == 0);
         mem_rdata  = 8'($urandom_range(0, 255));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
